// File: rtl/debounce_pkg.sv
// Shared definitions for the pushbutton debouncer and its pulse generator.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package debounce_pkg;

    // Debouncer FSM state codes; the encoding is fixed so that the codes
    // are stable when probed from outside the block.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,  // button released and debounced
        S_DB_HI = 3'd1,  // press seen, waiting for it to stay stable
        S_HELD  = 3'd2,  // press accepted, waiting for first repeat
        S_RPT   = 3'd3,  // auto-repeating at the repeat period
        S_DB_LO = 3'd4   // release seen, waiting for it to stay stable
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
// Latency: 2 clk cycles from input change to o_q.
// Backpressure: none; samples every cycle.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/debounce_pulse.sv
// Debounces a raw pushbutton into a level and one-cycle press/repeat pulses.
// Latency: pulse_out rises DB_TICKS+2 cycles after btn_in is sampled high and stays stable.
// Backpressure: none; pulses are fire-and-forget and never back-to-back.
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int DB_TICKS   = 1_000_000,
    parameter int RPT_DELAY  = 50_000_000,
    parameter int RPT_PERIOD = 10_000_000,
    parameter int CW         = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic rpt_en,
    output logic pulse_out,
    output logic level_out
);

    // Terminal counts; each state leaves or fires when its count is reached,
    // so the counter never needs to go past the largest of these.
    localparam logic [CW-1:0] DB_LIM  = CW'(DB_TICKS - 1);
    localparam logic [CW-1:0] DLY_LIM = CW'(RPT_DELAY - 1);
    localparam logic [CW-1:0] PER_LIM = CW'(RPT_PERIOD - 1);

    logic            w_sync_in;
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_pulse;
    logic            r_level;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (btn_in),
        .o_q   (w_sync_in)
    );

    // Debounce / auto-repeat FSM; one shared counter, cleared on every state
    // change. Release and repeat-disable are checked before any pulse-due
    // condition so they win when they coincide with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sync_in) begin
                        r_state <= S_DB_HI;
                        r_cnt   <= '0;
                    end
                end
                S_DB_HI: begin
                    if (!w_sync_in) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LIM) begin
                        r_state <= S_HELD;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HELD: begin
                    if (!w_sync_in) begin
                        r_state <= S_DB_LO;
                        r_cnt   <= '0;
                    end else if (!rpt_en) begin
                        // Repeat disabled: park the delay at its start.
                        r_cnt <= '0;
                    end else if (r_cnt == DLY_LIM) begin
                        r_state <= S_RPT;
                        r_cnt   <= '0;
                        r_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RPT: begin
                    if (!w_sync_in) begin
                        r_state <= S_DB_LO;
                        r_cnt   <= '0;
                    end else if (!rpt_en) begin
                        r_state <= S_HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == PER_LIM) begin
                        r_cnt   <= '0;
                        r_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DB_LO: begin
                    if (w_sync_in) begin
                        // Release bounce: back to held without a new press pulse.
                        r_state <= S_HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LIM) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_out = r_pulse;
    assign level_out = r_level;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse with short debounce/repeat timings.
// Latency: n/a.
// Backpressure: n/a.
module tb_debounce_pulse;
    import debounce_pkg::*;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic btn_in = 1'b0;
    logic rpt_en = 1'b0;
    logic pulse_out;
    logic level_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_p = -10;
    int n_b2b = 0;
    int t0;
    int tr;
    int tref;
    int pulses[$];
    int exp_q[$];

    debounce_pulse #(
        .DB_TICKS   (4),
        .RPT_DELAY  (20),
        .RPT_PERIOD (8),
        .CW         (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .rpt_en    (rpt_en),
        .pulse_out (pulse_out),
        .level_out (level_out)
    );

    always #5 clk = ~clk;

    // Edge counter: after the k-th rising edge cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse logger, sampled just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (pulse_out === 1'b1) begin
            if (last_p == cyc - 1) n_b2b++;
            last_p = cyc;
            pulses.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_pulses(input string tag);
        chk({tag, "_npulse"}, pulses.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < pulses.size(); i++)
            chk($sformatf("%s_p%0d", tag, i), pulses[i], exp_q[i]);
    endtask

    // Called at a negedge: press the button, sampled at edge t0.
    task automatic press();
        pulses.delete();
        btn_in = 1'b1;
        t0 = cyc + 1;
    endtask

    // Called at a negedge: release and check level_out drops exactly 6 edges later.
    task automatic release_chk(input string tag);
        btn_in = 1'b0;
        tr = cyc + 1;
        wait_n(6);
        chk({tag, "_lvl_hold"}, level_out, 1'b1);
        wait_n(1);
        chk({tag, "_lvl_drop"}, level_out, 1'b0);
        chk({tag, "_st_idle"}, dut.r_state, S_IDLE);
    endtask

    initial begin
        // Reset state
        wait_n(2);
        chk("rst_pulse", pulse_out, 1'b0);
        chk("rst_level", level_out, 1'b0);
        chk("rst_state", dut.r_state, S_IDLE);
        reset = 1'b0;
        wait_n(2);

        // 1: single press, no repeat
        rpt_en = 1'b0;
        press();
        wait_n(6);
        chk("t1_pulse_pre", pulse_out, 1'b0);
        chk("t1_lvl_pre", level_out, 1'b0);
        wait_n(1);
        chk("t1_pulse", pulse_out, 1'b1);
        chk("t1_lvl", level_out, 1'b1);
        wait_n(1);
        chk("t1_pulse_post", pulse_out, 1'b0);
        wait_n(22);
        chk("t1_lvl_held", level_out, 1'b1);
        release_chk("t1");
        exp_q = {t0 + 6};
        check_pulses("t1");
        wait_n(3);

        // 2: short bursts rejected
        pulses.delete();
        btn_in = 1'b1; wait_n(2);
        btn_in = 1'b0; wait_n(2);
        btn_in = 1'b1; wait_n(2);
        chk("t2_lvl_mid", level_out, 1'b0);
        btn_in = 1'b0; wait_n(10);
        exp_q = {};
        check_pulses("t2");
        chk("t2_lvl", level_out, 1'b0);
        chk("t2_state", dut.r_state, S_IDLE);

        // 3: auto-repeat while held 60 cycles
        rpt_en = 1'b1;
        press();
        wait_n(60);
        release_chk("t3");
        exp_q = {t0 + 6, t0 + 26, t0 + 34, t0 + 42, t0 + 50, t0 + 58};
        check_pulses("t3");
        wait_n(3);

        // 4: 2-cycle release glitch while held
        press();
        wait_n(11);
        btn_in = 1'b0;
        wait_n(2);
        btn_in = 1'b1;
        wait_n(1);
        chk("t4_st_dblo", dut.r_state, S_DB_LO);
        chk("t4_lvl_g0", level_out, 1'b1);
        wait_n(2);
        chk("t4_st_held", dut.r_state, S_HELD);
        chk("t4_lvl_g1", level_out, 1'b1);
        wait_n(39);
        release_chk("t4");
        exp_q = {t0 + 6, t0 + 35, t0 + 43, t0 + 51};
        check_pulses("t4");
        wait_n(3);

        // 5: reset mid-repeat with button held
        press();
        wait_n(31);
        chk("t5_st_rpt", dut.r_state, S_RPT);
        reset = 1'b1;
        #1;
        chk("t5_rst_lvl_now", level_out, 1'b0);
        chk("t5_rst_st_now", dut.r_state, S_IDLE);
        for (int i = 0; i < 3; i++) begin
            wait_n(1);
            chk($sformatf("t5_rst_pulse%0d", i), pulse_out, 1'b0);
            chk($sformatf("t5_rst_lvl%0d", i), level_out, 1'b0);
        end
        reset = 1'b0;
        pulses.delete();
        tref = cyc + 1;
        wait_n(12);
        exp_q = {tref + 6};
        check_pulses("t5");
        chk("t5_lvl", level_out, 1'b1);
        release_chk("t5");
        wait_n(3);

        // 6: drop rpt_en on the cycle a repeat pulse is due
        press();
        wait_n(34);
        chk("t6_st_rpt", dut.r_state, S_RPT);
        rpt_en = 1'b0;
        wait_n(1);
        chk("t6_st_held", dut.r_state, S_HELD);
        chk("t6_pulse", pulse_out, 1'b0);
        wait_n(20);
        chk("t6_st_held2", dut.r_state, S_HELD);
        chk("t6_lvl", level_out, 1'b1);
        exp_q = {t0 + 6, t0 + 26};
        check_pulses("t6");
        release_chk("t6");

        chk("no_back_to_back", n_b2b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
